nios_hps_system_pio_in_edge: RTL and testbench
==============================================

Name: nios_hps_system_pio_in_edge

Overview:
- Parametrised Avalon-MM slave input port: successor to the single-bit polled input PIO used on the Nios UART RX line.
- Generalises to WIDTH bits. Adds a per-bit input synchroniser, a per-bit debounce filter, per-bit edge capture with write-1-to-clear, an interrupt mask and a level interrupt to the Nios.
- Sits between board/HPS GPIO pins and the Nios data master. Readdata is registered, with fixed 1-cycle read latency.

Parameters:
- WIDTH, 8: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles before a bit's filtered value changes, 0..65535. Values 0 and 1 are equivalent (no filtering).
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge sets capture.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- address, input, 2: word address.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data.
- in_port, input, WIDTH: asynchronous external inputs.
- readdata, output, 32: registered read data.
- irq, output, 1: level interrupt, active high.

Behaviour:
- One clock (clk); reset is asynchronous and active-high, named reset. All flops clear on reset assertion, independent of clk.
- Reset values: readdata = 0, irq = 0, sync chain = 0, filtered value = 0, previous filtered value = 0, debounce counters = 0, mask = 0, edge capture = 0.
- Synchroniser: sync[0] <= in_port; sync[k] <= sync[k-1]; sync_out = sync[SYNC_STAGES-1].
- Debounce, per bit, counter width ceil(log2(max(DEBOUNCE_CYCLES,2)))):
  - If sync_out == filt: cnt <= 0.
  - Else if cnt == max(DEBOUNCE_CYCLES,1) - 1: filt <= sync_out, cnt <= 0.
  - Else: cnt <= cnt + 1.
  - A mismatch shorter than DEBOUNCE_CYCLES cycles leaves filt unchanged and resets cnt.
- Latency: a clean in_port change before edge 1 reaches filt after edge SYNC_STAGES + max(DEBOUNCE_CYCLES,1) and reaches capture/irq one edge later.
- Edge detect: filt_d <= filt each cycle.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - ev = rise, fall or (rise | fall), per EDGE_TYPE.
- Register map (wr = chipselect & ~write_n):
  - 0: DATA, read-only; reads {0, filt}. Writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2: IRQMASK, R/W; mask <= writedata[WIDTH-1:0].
  - 3: EDGECAP, R/W1C; reads {0, cap}.
- Capture update: cap <= (cap & ~(wr && address==3 ? writedata[WIDTH-1:0] : 0)) | ev. A new event in the same cycle as its clear wins; the bit stays set.
- Reads: readdata <= selected register every clk, not gated by chipselect. Value reflects register state before that edge's updates. Unused upper bits read 0.
- irq = |(cap & mask), driven from registers only (no combinational path from bus inputs). Mask written 0 drops irq the edge after the write; cap bits are retained.
- Reset out of a high input: filt rises from 0 after reset, so a rising edge is captured. Software clears EDGECAP after init. Reset asserted mid-debounce discards the count.
- Writes to unmapped bits above WIDTH are ignored.

Test Plan:
- Reset/readback (WIDTH=8, SYNC=2, DEB=4): reset with in_port=0x00. Read addr 0, 2, 3 → each returns 0x00000000; irq=0.
- Rising edge, EDGE_TYPE=0: write mask 0x01; in_port 0x00→0x01 before edge 1 → filt=0x01 after edge 6; cap=0x01 and irq=1 after edge 7; read addr 3 → 0x00000001.
- Glitch rejection: in_port bit 2 high for 3 cycles then low → DATA stays 0x00, cap stays 0x00, irq stays 0. A 4-cycle pulse → DATA bit 2 toggles 1 then back to 0, and cap[2]=1.
- W1C and collision: cap=0x05; write 0x04 to addr 3 → cap=0x01. Write 0x01 in the same cycle as a new bit-0 event → cap=0x01, irq stays 1.
- Masking/EDGE_TYPE=2: mask 0x00, toggle bit 7 high then low → cap=0x80, irq=0. Write mask 0x80 → irq=1 the edge after. Write 0x80 to addr 3 → irq=0.
- Async reset mid-operation: assert reset for 1 ns between edges with cap=0xFF, mask=0xFF → irq=0 and readdata=0 immediately without a clk edge. After deassert with in_port=0xFF → cap=0xFF after edge SYNC+DEB+1.

Source files
------------

// File: rtl/nios_hps_system_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// The slave modport also carries the level interrupt back to the Nios.
interface nios_hps_system_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_hps_system_pio_in_edge.sv
// Avalon-MM input PIO with per-bit synchroniser, debounce filter, edge capture (W1C),
// interrupt mask and level irq. Readdata is registered with a fixed one-cycle latency.
module nios_hps_system_pio_in_edge #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    in_port,
  nios_hps_system_pio_in_edge_if.slave        bus
);

  localparam int unsigned DebN = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebN - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]                  filt_q, filt_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [WIDTH-1:0]                  mask_q, mask_d;
  logic [WIDTH-1:0]                  cap_q, cap_d;
  logic [31:0]                       readdata_q, readdata_d;

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic             wr;

  // Upper writedata bits beyond WIDTH are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign wr       = bus.chipselect & ~bus.write_n;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
  end

  // Filter only flips after the mismatch has persisted for DebN consecutive cycles.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_out[i] != filt_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          filt_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  always_comb begin
    prev_d = filt_q;
    rise   = filt_q & ~prev_q;
    fall   = ~filt_q & prev_q;
    if (EDGE_TYPE == 0) begin
      ev = rise;
    end else if (EDGE_TYPE == 1) begin
      ev = fall;
    end else begin
      ev = rise | fall;
    end
  end

  // A new event in the same cycle as its clear keeps the bit set.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr && bus.address == 2'd2) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr && bus.address == 2'd3) begin
      clr = bus.writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~clr) | ev;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d = 32'(filt_q);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(cap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      filt_q     <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_hps_system_pio_in_edge.sv
// Self-checking bench: rising-edge and any-edge instances driven with identical stimulus,
// checked against directed constants and a cycle-level behavioural model.
module tb_nios_hps_system_pio_in_edge;

  localparam int unsigned W    = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_port = '0;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;

  int checks = 0;
  int failures = 0;

  nios_hps_system_pio_in_edge_if bus0();
  nios_hps_system_pio_in_edge_if bus2();

  assign bus0.address = address;
  assign bus0.chipselect = chipselect;
  assign bus0.write_n = write_n;
  assign bus0.writedata = writedata;
  assign bus2.address = address;
  assign bus2.chipselect = chipselect;
  assign bus2.write_n = write_n;
  assign bus2.writedata = writedata;

  nios_hps_system_pio_in_edge #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus0.slave)
  );

  nios_hps_system_pio_in_edge #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2)
  ) dut2 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  // Reference model: delay line, run-length debounce, edge sets for both edge types.
  logic [W-1:0] m_pipe [SYNC];
  int           m_run [W];
  logic [W-1:0] m_filt, m_prev, m_mask, m_cap0, m_cap2;
  logic [31:0]  m_rd0, m_rd2;
  logic [W-1:0] m_so, m_clr;

  task automatic model_clear();
    for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_filt = '0; m_prev = '0; m_mask = '0; m_cap0 = '0; m_cap2 = '0;
    m_rd0 = '0; m_rd2 = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        m_so = m_pipe[SYNC-1];
        case (address)
          2'd0: begin m_rd0 = {24'h0, m_filt}; m_rd2 = {24'h0, m_filt}; end
          2'd2: begin m_rd0 = {24'h0, m_mask}; m_rd2 = {24'h0, m_mask}; end
          2'd3: begin m_rd0 = {24'h0, m_cap0}; m_rd2 = {24'h0, m_cap2}; end
          default: begin m_rd0 = '0; m_rd2 = '0; end
        endcase
        m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        m_cap0 = (m_cap0 & ~m_clr) | (m_filt & ~m_prev);
        m_cap2 = (m_cap2 & ~m_clr) | (m_filt ^ m_prev);
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_prev = m_filt;
        for (int i = 0; i < W; i++) begin
          if (m_so[i] == m_filt[i]) begin
            m_run[i] = 0;
          end else if (m_run[i] + 1 >= DEB) begin
            m_filt[i] = m_so[i];
            m_run[i] = 0;
          end else begin
            m_run[i] = m_run[i] + 1;
          end
        end
        for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = in_port;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      if (a == 1) continue;
      address = 2'(a);
      step();
      checks++;
      if (bus0.readdata !== 32'h0 || bus2.readdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_read addr=%0d got=%h/%h exp=0", a, bus0.readdata, bus2.readdata);
      end
    end
    checks++;
    if (bus0.irq !== 1'b0 || bus2.irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b/%b exp=0", bus0.irq, bus2.irq);
    end
  endtask

  task automatic test_rising();
    bus_write(2'd2, 32'h1);
    address = 2'd0;
    in_port = 8'h01;
    steps(6);
    checks++;
    if (bus0.irq !== 1'b0) begin
      failures++;
      $display("FAIL rise_irq_early got=%b exp=0", bus0.irq);
    end
    step();
    checks++;
    if (bus0.readdata !== 32'h1) begin
      failures++;
      $display("FAIL rise_data got=%h exp=00000001", bus0.readdata);
    end
    checks++;
    if (bus0.irq !== 1'b1) begin
      failures++;
      $display("FAIL rise_irq got=%b exp=1", bus0.irq);
    end
    address = 2'd3;
    step();
    checks++;
    if (bus0.readdata !== 32'h1) begin
      failures++;
      $display("FAIL rise_cap got=%h exp=00000001", bus0.readdata);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    bus_write(2'd3, 32'hFF);
    address = 2'd0;
    in_port = 8'h05;
    steps(3);
    in_port = 8'h01;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus0.readdata[2] !== 1'b0 || bus0.irq !== 1'b0) begin
        failures++;
        $display("FAIL glitch_data cyc=%0d got=%h irq=%b exp=bit2 0 irq 0", i,
                 bus0.readdata, bus0.irq);
      end
    end
    address = 2'd3;
    step();
    checks++;
    if (bus0.readdata !== 32'h0 || bus2.readdata !== 32'h0) begin
      failures++;
      $display("FAIL glitch_cap got=%h/%h exp=0", bus0.readdata, bus2.readdata);
    end
    address = 2'd0;
    in_port = 8'h05;
    steps(4);
    in_port = 8'h01;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus0.readdata[2] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || bus0.readdata[2] !== 1'b0) begin
      failures++;
      $display("FAIL pulse_data seen=%b final=%b exp=seen 1 final 0", seen, bus0.readdata[2]);
    end
    address = 2'd3;
    step();
    checks++;
    if (bus0.readdata[2] !== 1'b1 || bus2.readdata[2] !== 1'b1) begin
      failures++;
      $display("FAIL pulse_cap got=%h/%h exp=bit2 set", bus0.readdata, bus2.readdata);
    end
  endtask

  task automatic test_w1c();
    in_port = 8'h00;
    steps(8);
    in_port = 8'h01;
    steps(8);
    step();
    checks++;
    if (bus0.readdata !== 32'h5 || bus2.readdata !== 32'h5) begin
      failures++;
      $display("FAIL w1c_pre got=%h/%h exp=00000005", bus0.readdata, bus2.readdata);
    end
    bus_write(2'd3, 32'h4);
    step();
    checks++;
    if (bus0.readdata !== 32'h1 || bus2.readdata !== 32'h1) begin
      failures++;
      $display("FAIL w1c_clear got=%h/%h exp=00000001", bus0.readdata, bus2.readdata);
    end
    in_port = 8'h00;
    steps(8);
    in_port = 8'h01;
    steps(6);
    bus_write(2'd3, 32'h1);
    step();
    checks++;
    if (bus0.readdata !== 32'h1 || bus2.readdata !== 32'h1) begin
      failures++;
      $display("FAIL w1c_collide got=%h/%h exp=00000001", bus0.readdata, bus2.readdata);
    end
    checks++;
    if (bus0.irq !== 1'b1) begin
      failures++;
      $display("FAIL w1c_collide_irq got=%b exp=1", bus0.irq);
    end
  endtask

  task automatic test_mask_any();
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h81;
    steps(8);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h01;
    steps(8);
    address = 2'd3;
    step();
    checks++;
    if (bus0.readdata !== 32'h0 || bus2.readdata !== 32'h80) begin
      failures++;
      $display("FAIL any_cap got=%h/%h exp=00000000/00000080", bus0.readdata, bus2.readdata);
    end
    checks++;
    if (bus0.irq !== 1'b0 || bus2.irq !== 1'b0) begin
      failures++;
      $display("FAIL any_masked_irq got=%b/%b exp=0/0", bus0.irq, bus2.irq);
    end
    bus_write(2'd2, 32'h80);
    checks++;
    if (bus0.irq !== 1'b0 || bus2.irq !== 1'b1) begin
      failures++;
      $display("FAIL any_unmask_irq got=%b/%b exp=0/1", bus0.irq, bus2.irq);
    end
    bus_write(2'd3, 32'h80);
    checks++;
    if (bus2.irq !== 1'b0) begin
      failures++;
      $display("FAIL any_clear_irq got=%b exp=0", bus2.irq);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      address = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n = ($urandom_range(0, 3) != 0);
      writedata = $urandom;
      step();
      checks++;
      if (bus0.readdata !== m_rd0 || bus2.readdata !== m_rd2) begin
        failures++;
        $display("FAIL rand_read cyc=%0d got=%h/%h exp=%h/%h", i, bus0.readdata,
                 bus2.readdata, m_rd0, m_rd2);
      end
      checks++;
      if (bus0.irq !== (|(m_cap0 & m_mask)) || bus2.irq !== (|(m_cap2 & m_mask))) begin
        failures++;
        $display("FAIL rand_irq cyc=%0d got=%b/%b exp=%b/%b", i, bus0.irq, bus2.irq,
                 |(m_cap0 & m_mask), |(m_cap2 & m_mask));
      end
    end
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic test_async_reset();
    in_port = 8'h00;
    steps(8);
    in_port = 8'hFF;
    steps(8);
    bus_write(2'd2, 32'hFF);
    address = 2'd3;
    step();
    checks++;
    if (bus0.readdata !== 32'hFF || bus0.irq !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got=%h irq=%b exp=000000ff irq 1", bus0.readdata, bus0.irq);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus0.irq !== 1'b0 || bus2.irq !== 1'b0 ||
        bus0.readdata !== 32'h0 || bus2.readdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got=%h/%h irq=%b/%b exp=0", bus0.readdata, bus2.readdata,
               bus0.irq, bus2.irq);
    end
    reset = 1'b0;
    bus_write(2'd2, 32'hFF);
    address = 2'd3;
    steps(5);
    checks++;
    if (bus0.irq !== 1'b0) begin
      failures++;
      $display("FAIL async_irq_early got=%b exp=0", bus0.irq);
    end
    step();
    checks++;
    if (bus0.irq !== 1'b1 || bus2.irq !== 1'b1) begin
      failures++;
      $display("FAIL async_irq got=%b/%b exp=1/1", bus0.irq, bus2.irq);
    end
    step();
    checks++;
    if (bus0.readdata !== 32'hFF || bus2.readdata !== 32'hFF) begin
      failures++;
      $display("FAIL async_cap got=%h/%h exp=000000ff", bus0.readdata, bus2.readdata);
    end
    checks++;
    if (bus0.readdata !== m_rd0 || bus2.readdata !== m_rd2) begin
      failures++;
      $display("FAIL async_model got=%h/%h exp=%h/%h", bus0.readdata, bus2.readdata,
               m_rd0, m_rd2);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rising();
    test_glitch();
    test_w1c();
    test_mask_any();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
